// File: rtl/uart_cmd_parser_if.sv
// Command bus between the UART command parser and the register-access stage.
// The parser drives the command fields and the error pulse; the consumer
// drives cmd_ready.
interface uart_cmd_parser_if #(
  parameter int ADDR_NIB = 2,
  parameter int DATA_NIB = 2
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_is_wr;
  logic [4*ADDR_NIB-1:0] cmd_addr;
  logic [4*DATA_NIB-1:0] cmd_wdata;
  logic                  cmd_err;

  modport master (
    output cmd_valid,
    output cmd_is_wr,
    output cmd_addr,
    output cmd_wdata,
    output cmd_err,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_is_wr,
    input  cmd_addr,
    input  cmd_wdata,
    input  cmd_err,
    output cmd_ready
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// ASCII command parser fed by the UART character decoder.
// Assembles "W AA DD<CR>" writes and "R AA<CR>" reads from one-cycle
// character strobes and offers them over a valid/ready handshake. Syntax
// errors and characters arriving while a command is pending raise a
// one-cycle cmd_err; after a syntax error the rest of the line is dropped.
module uart_cmd_parser #(
  parameter int ADDR_NIB = 2,
  parameter int DATA_NIB = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec_done,
  input  logic [3:0]        dec_out,
  input  logic              dec_write,
  input  logic              dec_read,
  input  logic              dec_space,
  input  logic              dec_cr,
  input  logic              dec_lf,
  input  logic              dec_fail,
  uart_cmd_parser_if.master cmd
);

  localparam int AW      = 4 * ADDR_NIB;
  localparam int DW      = 4 * DATA_NIB;
  localparam int MAX_NIB = (ADDR_NIB > DATA_NIB) ? ADDR_NIB : DATA_NIB;
  localparam int CNT_W   = $clog2(MAX_NIB + 1);

  localparam logic [CNT_W-1:0] ADDR_LIM = CNT_W'(ADDR_NIB);
  localparam logic [CNT_W-1:0] DATA_LIM = CNT_W'(DATA_NIB);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] OP_SP   = 3'd1;
  localparam logic [2:0] ADDR    = 3'd2;
  localparam logic [2:0] ADDR_SP = 3'd3;
  localparam logic [2:0] DATA    = 3'd4;
  localparam logic [2:0] ISSUE   = 3'd5;
  localparam logic [2:0] DISCARD = 3'd6;

  logic [2:0]       state_q, state_d;
  logic             is_wr_q, is_wr_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             syntax_err;

  // Character classes. A fail strobe overrides any other flag so a garbled
  // character can never be mistaken for a legal token.
  logic ch_any, ch_w, ch_r, ch_sp, ch_cr, ch_lf, ch_eol, ch_digit;

  assign ch_any   = dec_done;
  assign ch_w     = dec_done & ~dec_fail & dec_write;
  assign ch_r     = dec_done & ~dec_fail & dec_read;
  assign ch_sp    = dec_done & ~dec_fail & dec_space;
  assign ch_cr    = dec_done & ~dec_fail & dec_cr;
  assign ch_lf    = dec_done & ~dec_fail & dec_lf;
  assign ch_eol   = ch_cr | ch_lf;
  assign ch_digit = dec_done & ~(dec_fail | dec_write | dec_read |
                                 dec_space | dec_cr | dec_lf);

  // Next-state and next-output computation for one character (or none).
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    err_d      = 1'b0;
    syntax_err = 1'b0;

    // Handshake completes regardless of any character in the same cycle.
    if (valid_q && cmd.cmd_ready) begin
      valid_d = 1'b0;
      wdata_d = '0;
      state_d = IDLE;
    end

    if (ch_any) begin
      case (state_q)
        IDLE: begin
          if (ch_w) begin
            is_wr_d = 1'b1;
            state_d = OP_SP;
          end else if (ch_r) begin
            is_wr_d = 1'b0;
            state_d = OP_SP;
          end else if (!(ch_sp || ch_eol)) begin
            syntax_err = 1'b1;
          end
        end

        OP_SP: begin
          if (ch_sp) begin
            addr_d  = '0;
            wdata_d = '0;   // keeps cmd_wdata at zero for a read
            cnt_d   = '0;
            state_d = ADDR;
          end else begin
            syntax_err = 1'b1;
          end
        end

        ADDR: begin
          if (ch_digit && (cnt_q != ADDR_LIM)) begin
            addr_d = (addr_q << 4) | AW'(dec_out);
            cnt_d  = cnt_q + 1'b1;
          end else if (ch_sp && (cnt_q == ADDR_LIM) && is_wr_q) begin
            state_d = ADDR_SP;
          end else if (ch_cr && (cnt_q == ADDR_LIM) && !is_wr_q) begin
            valid_d = 1'b1;
            state_d = ISSUE;
          end else begin
            syntax_err = 1'b1;
          end
        end

        ADDR_SP: begin
          // The first data digit is taken here, so DATA starts at count 1.
          if (ch_digit) begin
            wdata_d = DW'(dec_out);
            cnt_d   = CNT_W'(1);
            state_d = DATA;
          end else begin
            syntax_err = 1'b1;
          end
        end

        DATA: begin
          if (ch_digit && (cnt_q != DATA_LIM)) begin
            wdata_d = (wdata_q << 4) | DW'(dec_out);
            cnt_d   = cnt_q + 1'b1;
          end else if (ch_cr && (cnt_q == DATA_LIM)) begin
            valid_d = 1'b1;
            state_d = ISSUE;
          end else begin
            syntax_err = 1'b1;
          end
        end

        ISSUE: begin
          // Overrun: the character is dropped, the pending command is kept.
          if (!ch_lf) err_d = 1'b1;
        end

        DISCARD: begin
          if (ch_eol) state_d = IDLE;
        end

        default: state_d = IDLE;
      endcase
    end

    // A line end that is itself the offending character already resyncs.
    if (syntax_err) begin
      err_d   = 1'b1;
      state_d = ch_eol ? IDLE : DISCARD;
    end
  end

  // Parser state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register takes its new
      // value together at the edge, independent of statement order.
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign cmd.cmd_valid = valid_q;
  assign cmd.cmd_is_wr = is_wr_q;
  assign cmd.cmd_addr  = addr_q;
  assign cmd.cmd_wdata = wdata_q;
  assign cmd.cmd_err   = err_q;

endmodule
